// File: rtl/picorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// picorv32_mem_arbiter
//
// Shares one PicoRV32 native memory port between two requesters: requester 0
// (the core) and requester 1 (debug/DMA). The owner of the port is chosen
// while the port is idle. The owner keeps the port until mem_ready, even if it
// drops its valid. At least one idle cycle separates back-to-back transactions.
//
// A wait counter measures how long the current owner has waited. When it
// reaches TIMEOUT, a sticky error flag sets. The grant itself is never aborted.
//
// Configuration:
//   PICORV32_MEM_ARB_RR_EN  defined   : when both requesters ask at once, the
//                                       one not served last wins (round robin)
//   PICORV32_MEM_ARB_RR_EN  undefined : requester 0 always wins a tie
//
// Parameters:
//   TIMEOUT    grant-cycle count that sets err_timeout (0 disables the flag)
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   m0_* / m1_*                      requester request fields, ready and rdata
//   mem_valid/instr/addr/wdata/wstrb shared request towards the AXI adapter
//   mem_ready, mem_rdata             shared port response
//   grant_id                         current owner (valid while mem_valid=1)
//   err_timeout                      sticky timeout flag
// -----------------------------------------------------------------------------
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        grant_id,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
`ifdef PICORV32_MEM_ARB_RR_EN
  logic        last_q, last_d;   // requester that received the most recent grant
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement. This way
    // no path leaves a variable unassigned, and no latch is inferred.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`ifdef PICORV32_MEM_ARB_RR_EN
    last_d     = last_q;
`endif

    case (state_q)
      IDLE: begin
        // The counter is held at zero here, so each grant starts counting at 0.
        wait_cnt_d = '0;
        if (m0_valid && m1_valid) begin
`ifdef PICORV32_MEM_ARB_RR_EN
          state_d = last_q ? GNT0 : GNT1;
`else
          state_d = GNT0;
`endif
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
`ifdef PICORV32_MEM_ARB_RR_EN
        if (state_d != IDLE) last_d = (state_d == GNT1);
`endif
      end

      GNT0, GNT1: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 32'd1;
          // The flag sets in the same cycle the counter reaches TIMEOUT.
          if ((TIMEOUT != 0) && (wait_cnt_d == TIMEOUT)) err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: use non-blocking assignments for all sequential state. Every register
  // then samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef PICORV32_MEM_ARB_RR_EN
  // After reset the pointer points at requester 1, so the first tie goes to
  // requester 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // These outputs decode directly from state_q. A reset forces IDLE, so they
  // clear at once, and no ready pulse can reach an abandoned requester.
  assign mem_valid   = (state_q != IDLE);
  assign grant_id    = (state_q == GNT1);
  assign err_timeout = err_q;

  assign m0_ready = mem_ready && (state_q == GNT0);
  assign m1_ready = mem_ready && (state_q == GNT1);
  assign m0_rdata = (state_q == GNT0) ? mem_rdata : 32'd0;
  assign m1_rdata = (state_q == GNT1) ? mem_rdata : 32'd0;

  // Request fields come straight from the owner, with no register stage. When
  // the port is idle they are driven to zero.
  always_comb begin
    mem_instr = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    case (state_q)
      GNT0: begin
        mem_instr = m0_instr;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
      end
      GNT1: begin
        mem_instr = m1_instr;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_picorv32_mem_arbiter
//
// Two requester drivers take requests from per-requester queues. Each issued
// request pushes its expected completion into a scoreboard queue. A memory
// model answers the shared port: rdata is addr ^ KEY, and the latency is random
// or forced. Every cycle a monitor compares the DUT against a transaction-level
// model of the port (busy/owner/tie-break/timeout rules). On each ready pulse
// it pops the scoreboard and checks the completion.
// -----------------------------------------------------------------------------
module tb_picorv32_mem_arbiter;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] KEY = 32'hCAFEF10D;   // 0x100 ^ KEY = 0xCAFEF00D

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gap;
    bit          drop;
  } req_t;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        drv_valid [2];
  logic        drv_instr [2];
  logic [31:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic [3:0]  drv_wstrb [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant_id, err_timeout;

  logic [1:0]  rdy;
  logic [31:0] rdat [2];
  assign rdy     = {m1_ready, m0_ready};
  assign rdat[0] = m0_rdata;
  assign rdat[1] = m1_rdata;

  req_t req_q [2][$];
  exp_t exp_q [2][$];
  bit   drv_busy [2];
  int   lat_override;
  bit   stray_en;
  int   n_total, n_bad;

  picorv32_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (drv_valid[0]),
    .m0_instr   (drv_instr[0]),
    .m0_addr    (drv_addr[0]),
    .m0_wdata   (drv_wdata[0]),
    .m0_wstrb   (drv_wstrb[0]),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (drv_valid[1]),
    .m1_instr   (drv_instr[1]),
    .m1_addr    (drv_addr[1]),
    .m1_wdata   (drv_wdata[1]),
    .m1_wstrb   (drv_wstrb[1]),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .grant_id   (grant_id),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr       = $urandom;
    r.addr[1:0]  = 2'b00;
    r.wdata      = $urandom;
    r.wstrb      = 4'($urandom);
    r.instr      = 1'($urandom);
    r.gap        = $urandom_range(0, 3);
    r.drop       = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Requester drivers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_drv
    initial begin
      req_t r;
      exp_t e;
      int   cyc;
      bit   dropped;
      drv_valid[g] = 1'b0;
      drv_instr[g] = 1'b0;
      drv_addr[g]  = '0;
      drv_wdata[g] = '0;
      drv_wstrb[g] = '0;
      drv_busy[g]  = 1'b0;
      @(posedge clk); #1;
      forever begin
        while (req_q[g].size() == 0) begin @(posedge clk); #1; end
        r = req_q[g].pop_front();
        drv_busy[g]  = 1'b1;
        drv_instr[g] = r.instr;
        drv_addr[g]  = r.addr;
        drv_wdata[g] = r.wdata;
        drv_wstrb[g] = r.wstrb;
        drv_valid[g] = 1'b1;
        e.instr = r.instr;
        e.addr  = r.addr;
        e.wdata = r.wdata;
        e.wstrb = r.wstrb;
        e.rdata = r.addr ^ KEY;
        exp_q[g].push_back(e);
        cyc = 0;
        dropped = 1'b0;
        forever begin
          @(negedge clk); #1;
          if (!resetn || rdy[g]) break;
          cyc++;
          if (cyc > 2000) begin
            n_total++;
            n_bad++;
            $display("FAIL m%0d_ready_wait: got no ready expected ready within 2000 cycles", g);
            break;
          end
          // Drop valid part-way through the grant. The ready pulse must still come.
          if (r.drop && !dropped && mem_valid && (grant_id == 1'(g))) begin
            @(posedge clk); #1;
            drv_valid[g] = 1'b0;
            dropped = 1'b1;
          end
        end
        @(posedge clk); #1;
        drv_valid[g] = 1'b0;
        repeat (r.gap) begin @(posedge clk); #1; end
        drv_busy[g] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory model: updates at the falling edge
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    bit sbusy;
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat = 0;
    sbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mem_ready = 1'b1;            // stray response while the arbiter is in reset
        mem_rdata = $urandom;
        sbusy = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        sbusy = 1'b0;
      end else if (mem_valid) begin
        if (!sbusy) begin
          sbusy = 1'b1;
          lat = (lat_override >= 0) ? lat_override : $urandom_range(0, 3);
        end
        if (lat == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr ^ KEY;
        end else begin
          lat--;
        end
      end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
        mem_ready = 1'b1;            // stray response while idle
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor + reference model: samples 2 time units after the falling edge
  // ---------------------------------------------------------------------------
  initial begin
    bit          exp_busy, exp_owner, exp_last, exp_err, own;
    int unsigned waits;
    exp_t        e;
    exp_busy = 1'b0; exp_owner = 1'b0; exp_last = 1'b1; exp_err = 1'b0; waits = 0;
    forever begin
      @(negedge clk); #2;
      if (!resetn) begin
        exp_busy = 1'b0; exp_owner = 1'b0; exp_last = 1'b1; exp_err = 1'b0; waits = 0;
        exp_q[0].delete();
        exp_q[1].delete();
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        continue;
      end

      check("mem_valid", 32'(mem_valid), 32'(exp_busy));
      if (exp_busy) begin
        check("grant_id", 32'(grant_id), 32'(exp_owner));
      end else begin
        check("idle_grant_id", 32'(grant_id), 32'd0);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_mem_wdata", mem_wdata, 32'd0);
        check("idle_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("idle_mem_instr", 32'(mem_instr), 32'd0);
      end

      for (int x = 0; x < 2; x++) begin
        own = exp_busy && (exp_owner == 1'(x));
        check($sformatf("m%0d_ready", x), 32'(rdy[x]), 32'(own && mem_ready));
        check($sformatf("m%0d_rdata", x), rdat[x], own ? mem_rdata : 32'd0);
        if (rdy[x]) begin
          if (exp_q[x].size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL m%0d_unexpected_ready: got ready expected no outstanding request", x);
          end else begin
            e = exp_q[x].pop_front();
            check($sformatf("m%0d_sb_rdata", x), rdat[x], e.rdata);
            check($sformatf("m%0d_sb_addr", x), mem_addr, e.addr);
            check($sformatf("m%0d_sb_wdata", x), mem_wdata, e.wdata);
            check($sformatf("m%0d_sb_wstrb", x), 32'(mem_wstrb), 32'(e.wstrb));
            check($sformatf("m%0d_sb_instr", x), 32'(mem_instr), 32'(e.instr));
          end
        end
      end

      check("err_timeout", 32'(err_timeout), 32'(exp_err));

      // Port rules applied at the coming rising edge
      if (exp_busy) begin
        if (mem_ready) begin
          exp_busy = 1'b0;
        end else begin
          if (waits != 32'hFFFF_FFFF) waits++;
          if ((TMO != 0) && (waits >= TMO)) exp_err = 1'b1;
        end
      end else if (drv_valid[0] || drv_valid[1]) begin
        if (drv_valid[0] && drv_valid[1]) begin
`ifdef PICORV32_MEM_ARB_RR_EN
          exp_owner = ~exp_last;
`else
          exp_owner = 1'b0;
`endif
        end else begin
          exp_owner = drv_valid[1];
        end
        exp_last = exp_owner;
        exp_busy = 1'b1;
        waits = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (req_q[0].size() == 0 && req_q[1].size() == 0 && !drv_busy[0] && !drv_busy[1] &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic push_req(input int x, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int gap);
    req_t r;
    r.instr = instr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    r.gap = gap; r.drop = 1'b0;
    req_q[x].push_back(r);
  endtask

  initial begin
    bit seen;
    n_total = 0;
    n_bad = 0;
    resetn = 1'b0;
    lat_override = -1;
    stray_en = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;

    // Random mixed traffic from both requesters, with stray responses
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_q[0].push_back(rand_req());
      req_q[1].push_back(rand_req());
    end
    drain();
    stray_en = 1'b0;

    // Single read from requester 0: ready on the third grant cycle
    lat_override = 2;
    push_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2);
    drain();

    // Single write from requester 1 while requester 0 is idle
    lat_override = 1;
    push_req(1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'hF, 2);
    drain();

    // Both requesters held with back-to-back requests
    lat_override = 0;
    for (int i = 0; i < 3; i++) begin
      push_req(0, 1'b1, 32'h0000_0400 + 32'(i * 4), 32'(i), 4'h3, 0);
      push_req(1, 1'b0, 32'h0000_8000 + 32'(i * 4), 32'(i + 16), 4'hC, 0);
    end
    drain();

    // A long wait sets the sticky timeout flag. The transaction still completes.
    lat_override = 20;
    push_req(0, 1'b0, 32'h0000_0800, 32'h0, 4'h0, 1);
    drain();
    lat_override = -1;
    push_req(1, 1'b0, 32'h0000_0900, 32'h55AA_55AA, 4'h5, 1);
    drain();

    // Reset asserted in the middle of a grant
    lat_override = 10;
    push_req(0, 1'b0, 32'h0000_0C00, 32'h0, 4'h0, 0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (mem_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_test_granted", 32'(seen), 32'd1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("rst_imm_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_imm_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_imm_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_imm_grant_id", 32'(grant_id), 32'd0);
    check("rst_imm_err_timeout", 32'(err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    #3 resetn = 1'b1;
    lat_override = -1;
    stray_en = 1'b1;
    repeat (5) @(posedge clk);
    drain();

    // More random traffic after the reset
    for (int i = 0; i < 10; i++) begin
      req_q[0].push_back(rand_req());
      req_q[1].push_back(rand_req());
    end
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: grant-cycle count at which the sticky timeout flag sets (0 disables).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 m0_valid, m0_instr  in  1 each  requester 0 (core) native mem request.
REQ-005 m0_addr, m0_wdata  in  32 each; m0_wstrb  in  4  requester 0 request fields.
REQ-006 m0_ready  out  1; m0_rdata  out  32  requester 0 completion.
REQ-007 m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  requester 1 (debug/DMA) request.
REQ-008 m1_ready  out  1; m1_rdata  out  32  requester 1 completion.
REQ-009 mem_valid, mem_instr  out  1 each; mem_addr, mem_wdata  out  32; mem_wstrb  out  4  shared port towards the AXI adapter.
REQ-010 mem_ready  in  1; mem_rdata  in  32  shared port response.
REQ-011 grant_id  out  1  requester owning the port (valid while mem_valid=1).
REQ-012 err_timeout  out  1  sticky timeout flag.

Function
REQ-013 FSM states IDLE, GNT0, GNT1; mem_valid SHALL equal (state != IDLE), registered.
REQ-014 IDLE with any mx_valid at cycle N: state becomes GNTx at N+1; mem_valid=1 from N+1.
REQ-015 In GNTx, mem_addr/wdata/wstrb/instr SHALL be combinationally muxed from requester x; in IDLE they SHALL be 0.
REQ-016 mx_ready SHALL equal mem_ready AND (state==GNTx), same cycle; mx_rdata SHALL equal mem_rdata when granted, else 0.
REQ-017 The non-granted requester's ready SHALL stay 0; its request stays pending, unmodified.
REQ-018 mem_ready in GNTx at cycle M: state returns to IDLE at M+1; minimum one IDLE cycle between transactions.
REQ-019 Grant SHALL be held until mem_ready regardless of mx_valid; a requester dropping valid mid-grant still receives its ready pulse.
REQ-020 mem_ready while IDLE SHALL be ignored (no ready to any requester, no state change).
REQ-021 Wait counter, 32-bit, SHALL clear on entering GNTx and increment each GNTx cycle without mem_ready, saturating.
REQ-022 When TIMEOUT != 0 and counter reaches TIMEOUT, err_timeout SHALL set and remain 1 until reset; grant is NOT aborted.
REQ-023 grant_id SHALL be 1 in GNT1, 0 otherwise.

Reset
REQ-024 resetn low SHALL immediately force state IDLE, mem_valid=0, m0_ready=m1_ready=0, grant_id=0, err_timeout=0, counter=0, last-served pointer=1.
REQ-025 Reset asserted mid-grant SHALL abandon the transaction; no ready pulse is issued to either requester afterwards.

Configuration
REQ-026 Macro PICORV32_MEM_ARB_RR_EN defined: simultaneous requests in IDLE SHALL grant the requester not last served; pointer updates on each grant.
REQ-027 Macro undefined: fixed priority, m0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-028 m0_valid=1 addr 0x100, wstrb 0 at cycle 0; mem_ready at cycle 3 rdata 0xCAFEF00D -> mem_valid 1-3, mem_addr 0x100, m0_ready=1 and m0_rdata 0xCAFEF00D at cycle 3, IDLE at 4.
REQ-029 m0 and m1 valid at cycle 0, mem_ready 1 cycle after each grant -> RR build: grants m0, m1, m0 alternating; fixed build: m0 served continuously while held, m1 never.
REQ-030 m1 write addr 0x2000 wdata 0x12345678 wstrb 0xF while m0 idle -> grant_id=1, mem fields match, m1_ready pulse only; m0_ready stays 0.
REQ-031 TIMEOUT=8, grant with no mem_ready for 20 cycles -> err_timeout rises on 8th wait cycle, stays 1; later mem_ready still completes normally.
REQ-032 resetn low in GNT0 at cycle 2, mem_ready at cycle 3 -> mem_valid 0 immediately, no m0_ready, err_timeout 0; stray mem_ready in IDLE produces no ready.
